four_bit_up_down_counter: RTL and testbench

- 4-bit synchronous binary up/down counter with synchronous clear.
- Count advances by one on every rising clock edge: up or down, selected by UD.
- Leaf block for small sequencing/timing uses. The output is directly the state register; there is no internal pipeline.

---
 rtl/four_bit_up_down_counter.sv | 28 ++
 tb/tb_four_bit_up_down_counter.sv | 116 +++++++++++
 2 files changed

// File: rtl/four_bit_up_down_counter.sv
// Synchronous binary up/down counter with synchronous clear.
// Count is the state register itself, so it changes only on a rising CLK edge.
module four_bit_up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             UD,
  output logic [WIDTH-1:0] Count,
  input  logic             Clear
);

  // Initialised so simulation shows a defined value before the first Clear.
  logic [WIDTH-1:0] countReg = '0;

  // Clear outranks direction; there is no hold state, and wrap-around is the
  // natural modulo-2^WIDTH behaviour of the adder.
  always_ff @(posedge CLK) begin
    if (Clear)
      countReg <= '0;
    else if (UD)
      countReg <= countReg + 1'b1;
    else
      countReg <= countReg - 1'b1;
  end

  assign Count = countReg;

endmodule

// File: tb/tb_four_bit_up_down_counter.sv
// Directed bench for four_bit_up_down_counter: a reference model pushes expected
// counts into a scoreboard queue, which is popped and asserted after every edge.
module tb_four_bit_up_down_counter;

  localparam int WIDTH = 4;

  logic             CLK = 1'b0;
  logic             UD = 1'b1;
  logic             Clear = 1'b0;
  logic [WIDTH-1:0] Count;

  logic [WIDTH-1:0] model = '0;
  logic [WIDTH-1:0] expectQ[$];
  int               checkCount = 0;
  int               errorCount = 0;

  four_bit_up_down_counter #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .UD   (UD),
    .Count(Count),
    .Clear(Clear)
  );

  always #5 CLK = ~CLK;

  // Pops the oldest expected value and compares it with what the DUT shows now.
  task automatic checkOutput(input string tag);
    logic [WIDTH-1:0] expected;
    checkCount++;
    if (expectQ.size() == 0) begin
      errorCount++;
      $error("[TB] FAIL %s: scoreboard empty, observed %0d", tag, Count);
    end else begin
      expected = expectQ.pop_front();
      assert (Count === expected) else begin
        errorCount++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, Count, expected);
      end
    end
  endtask

  // Drives one edge's inputs, advances the model, then checks just after the edge.
  task automatic applyStimulus(input logic clr, input logic dir, input string tag);
    Clear = clr;
    UD    = dir;
    if (clr)
      model = '0;
    else if (dir)
      model = model + 1'b1;
    else
      model = model - 1'b1;
    expectQ.push_back(model);
    @(posedge CLK);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #1;
    expectQ.push_back('0);
    checkOutput("powerup");

    applyStimulus(1'b1, 1'b1, "clear0");
    applyStimulus(1'b1, 1'b1, "clear1");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "release_up");

    applyStimulus(1'b1, 1'b0, "pre_upwrap");
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, "up_wrap");

    applyStimulus(1'b1, 1'b1, "pre_downwrap");
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0, "down_wrap");

    applyStimulus(1'b1, 1'b1, "pre_from3");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "to3");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, "down_from3");

    applyStimulus(1'b1, 1'b0, "pre_reverse");
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, "to9");
    applyStimulus(1'b0, 1'b0, "reverse_8");
    applyStimulus(1'b0, 1'b0, "reverse_7");
    applyStimulus(1'b0, 1'b1, "reverse_back_8");

    applyStimulus(1'b1, 1'b1, "pre_midclear");
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, "to12");
    applyStimulus(1'b1, 1'b1, "midclear0");
    applyStimulus(1'b1, 1'b1, "midclear1");
    applyStimulus(1'b0, 1'b0, "release_down15");
    applyStimulus(1'b0, 1'b0, "release_down14");

    applyStimulus(1'b1, 1'b1, "clear_ud1");
    applyStimulus(1'b1, 1'b0, "clear_ud0");
    applyStimulus(1'b0, 1'b1, "after_clear_ud");

    // Clear pulse that never coincides with an edge must leave Count alone.
    Clear = 1'b1;
    #3;
    expectQ.push_back(model);
    checkOutput("pulse_during");
    Clear = 1'b0;
    #1;
    expectQ.push_back(model);
    checkOutput("pulse_after");
    applyStimulus(1'b0, 1'b1, "pulse_next_edge");
    applyStimulus(1'b0, 1'b1, "pulse_next_edge2");

    if (expectQ.size() != 0) begin
      checkCount++;
      errorCount++;
      $error("[TB] FAIL scoreboard_drain: observed %0d left, expected 0", expectQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
